mips32_imem_loader: RTL and testbench
=====================================

# mips32_imem_loader

Program loader that fills the MIPS32 core's 512-word instruction memory from a byte stream and holds the core until a valid image is in place. It sits between a host byte source (UART receiver, debug port) and the instruction-memory write port. It accepts a framed image of length, payload and checksum, packs the payload into 32-bit words, and writes them from address 0 upward. It releases `core_hold` only after the checksum matches.

## Interface
- `DEPTH`, 512: instruction-memory depth in words; the maximum legal image length.
- `ADDR_W`, 9: memory address width, equal to clog2(DEPTH).

- `clk`  in  1  single clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle pulse that begins (or restarts) a load session
- `rx_data`  in  8  incoming byte
- `rx_valid`  in  1  `rx_data` is valid
- `rx_ready`  out  1  loader accepts a byte this cycle
- `mem_we`  out  1  instruction-memory write strobe
- `mem_addr`  out  ADDR_W  write address (word index)
- `mem_wdata`  out  32  write data
- `core_hold`  out  1  keeps the core in reset or halted while high
- `done`  out  1  image loaded and verified (sticky)
- `error`  out  1  bad length or checksum (sticky)
- `word_cnt`  out  ADDR_W+1  words written in the current session

## Operation
- A byte is accepted on a cycle where `rx_valid && rx_ready`.
- Frame format, in order:
  - LEN_HI byte, then LEN_LO byte; N = {LEN_HI, LEN_LO}.
  - 4·N payload bytes, most significant byte first within each word.
  - One checksum byte, equal to the XOR of all payload bytes.
- States:
  - IDLE → (`start`) LEN_HI → LEN_LO.
  - LEN_LO → DATA when 1 ≤ N ≤ DEPTH; otherwise → ERROR.
  - DATA → CHECK after the 4·N-th payload byte.
  - CHECK → DONE if the checksum matches; otherwise → ERROR.
- `start` in any state (including DONE and ERROR) jumps to LEN_HI. It clears `done`, `error`, `word_cnt`, the byte-lane counter and the checksum accumulator, and raises `core_hold`. `start` has priority over a byte accepted in the same cycle; that byte is ignored.
- `rx_ready` = 1 in LEN_HI, LEN_LO, DATA and CHECK; 0 in IDLE, DONE and ERROR.
- DATA:
  - A 2-bit lane counter shifts bytes into a 32-bit packer.
  - On the 4th byte the packed word is written to address `word_cnt`, then `word_cnt` increments.
  - Addresses run 0..N−1 with no wrap; N ≤ DEPTH guarantees this.
- The checksum accumulator is 8 bits, XORs payload bytes only, and is reset at session start.
- `core_hold` = 0 only in DONE.
- ERROR: words already written stay in memory. `core_hold` stays 1 until a later successful session.
- Reset values: `rx_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `core_hold`=1, `done`=0, `error`=0, `word_cnt`=0, state IDLE.
- Reset mid-session returns to IDLE. Partial memory contents are left untouched.

## Timing
- Throughput is one byte per cycle; `rx_valid` gaps of any length are tolerated with no state change.
- `mem_we` is registered. It pulses for exactly one cycle, the cycle after the 4th byte of a word is accepted, with `mem_addr` and `mem_wdata` stable during the pulse.
- `word_cnt` updates in the same cycle as the `mem_we` pulse.
- The last word's write and entry to CHECK occur in the same cycle.
- `done` or `error` plus the `core_hold` change appear the cycle after the checksum byte is accepted.
- A length error is flagged the cycle after LEN_LO is accepted; no `mem_we` occurs.
- Minimum session length is 4·N+3 accepted bytes, so DONE is reached 4·N+3 cycles after the first byte when bytes are back-to-back.

## Structure
- Package `mips32_loader_pkg` holds:
  - the state enum (IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERROR);
  - `IMEM_DEPTH` = 512;
  - the frame header length constant (2).
- Sub-module `mips32_byte_packer`:
  - byte-lane counter and 32-bit shift register;
  - outputs `word_valid` and `word`;
  - cleared by `start` or `rst`.

## Test plan
- Load N=2 (bytes 00 02 28 01 00 05 FC 00 00 00 D0) → mem[0]=0x28010005, mem[1]=0xFC000000. `done`=1, `core_hold`=0, `word_cnt`=2, `error`=0.
- Same frame with checksum 0xD1 → both words written, `error`=1, `done`=0, `core_hold`=1.
- Length boundaries:
  - N=0 → `error` the cycle after LEN_LO, no `mem_we`.
  - N=513 (02 01) → same.
  - N=512 → last write at `mem_addr`=511, `word_cnt`=512, `done`=1.
- Frame 1 with random 0–5 cycle `rx_valid` gaps → identical writes and result; `rx_ready` stays 1 throughout LEN_HI..CHECK.
- `rst` after 6 accepted bytes → only mem[0] written; IDLE, `rx_ready`=0, `core_hold`=1. A following `start` plus frame 1 succeeds.
- `start` asserted mid-DATA, coincident with an accepted byte → that byte is ignored, `word_cnt`=0, state LEN_HI. A new frame loads from address 0.

Source files
------------

// File: rtl/mips32_loader_pkg.sv
// Shared types and constants for the MIPS32 instruction-memory loader.
package mips32_loader_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK, S_DONE, S_ERROR
  } state_t;

  localparam int IMEM_DEPTH = 512;
  localparam int HDR_LEN    = 2;
endpackage

// File: rtl/mips32_byte_packer.sv
// Packs a byte stream into big-endian 32-bit words; emits a one-cycle word_valid.
module mips32_byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [1:0]  lane,
  output logic        word_valid,
  output logic [31:0] word
);
  logic [23:0] sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      lane       <= '0;
      sr         <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else if (clr) begin
      lane       <= '0;
      sr         <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (byte_en) begin
        lane <= lane + 2'd1;
        sr   <= {sr[15:0], byte_in};
        // word is held after the pulse so the write data stays put
        if (lane == 2'd3) begin
          word       <= {sr, byte_in};
          word_valid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/mips32_imem_loader.sv
// Framed image loader: LEN_HI, LEN_LO, 4*N payload bytes, XOR checksum; holds core until verified.
module mips32_imem_loader
  import mips32_loader_pkg::*;
#(
  parameter int DEPTH  = IMEM_DEPTH,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_cnt
);
  state_t          state, nxt;
  logic            acc, len_ok, last_byte;
  logic [7:0]      len_hi, csum;
  logic [ADDR_W:0] len;
  logic [15:0]     n16;
  logic [1:0]      lane;

  assign acc       = rx_valid && rx_ready;
  assign n16       = {len_hi, rx_data};
  assign len_ok    = (n16 != 16'd0) && (n16 <= 16'(DEPTH));
  assign last_byte = (lane == 2'd3) && ((word_cnt + 1'b1) == len);

  mips32_byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (start),
    .byte_en    (acc && (state == S_DATA) && !start),
    .byte_in    (rx_data),
    .lane       (lane),
    .word_valid (mem_we),
    .word       (mem_wdata)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (start) nxt = S_LEN_HI;
    else if (acc) begin
      case (state)
        S_LEN_HI: nxt = S_LEN_LO;
        S_LEN_LO: nxt = len_ok ? S_DATA : S_ERROR;
        S_DATA:   if (last_byte) nxt = S_CHECK;
        S_CHECK:  nxt = (rx_data == csum) ? S_DONE : S_ERROR;
        default:  nxt = state;
      endcase
    end
  end

  always_comb begin
    rx_ready  = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                (state == S_DATA)   || (state == S_CHECK);
    core_hold = (state != S_DONE);
    done      = (state == S_DONE);
    error     = (state == S_ERROR);
  end

  // Address is latched with the old count so it lines up with the registered mem_we
  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt <= '0;
      mem_addr <= '0;
      csum     <= '0;
      len_hi   <= '0;
      len      <= '0;
    end else if (start) begin
      word_cnt <= '0;
      csum     <= '0;
    end else if (acc) begin
      case (state)
        S_LEN_HI: len_hi <= rx_data;
        S_LEN_LO: len    <= n16[ADDR_W:0];
        S_DATA: begin
          csum <= csum ^ rx_data;
          if (lane == 2'd3) begin
            mem_addr <= word_cnt[ADDR_W-1:0];
            word_cnt <= word_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mips32_imem_loader.sv
// Randomized self-checking bench for mips32_imem_loader against a frame-level model.
module tb_mips32_imem_loader;
  localparam int DEPTH = 512;

  logic        clk = 1'b0;
  logic        rst, start, rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready, mem_we, core_hold, done, error;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [9:0]  word_cnt;

  int total = 0;
  int bad   = 0;

  logic [31:0] tb_mem [DEPTH];
  int          we_cnt = 0;
  int          viol   = 0;
  logic [8:0]  last_addr = '0;

  logic [31:0] words   [$];
  logic [7:0]  frame_q [$];

  mips32_imem_loader dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_hold(core_hold), .done(done), .error(error), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  // Bench-side memory image; during a write the count must already be one past the address
  always @(posedge clk) begin
    if (mem_we === 1'b1) begin
      tb_mem[mem_addr] <= mem_wdata;
      we_cnt    <= we_cnt + 1;
      last_addr <= mem_addr;
      if (word_cnt !== ({1'b0, mem_addr} + 10'd1)) viol <= viol + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame = N (big-endian 16 bit), payload MSB-first, XOR of payload (optionally corrupted)
  task automatic build_frame(input int n, input bit corrupt);
    logic [7:0] x;
    x = 8'h00;
    frame_q.delete();
    frame_q.push_back(8'((n >> 8) & 255));
    frame_q.push_back(8'(n & 255));
    foreach (words[i])
      for (int b = 3; b >= 0; b--) begin
        frame_q.push_back(8'((words[i] >> (8 * b)) & 255));
        x = x ^ 8'((words[i] >> (8 * b)) & 255);
      end
    frame_q.push_back(corrupt ? (x ^ 8'h01) : x);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_bytes(input int cnt, input int max_gap);
    for (int i = 0; i < cnt; i++) begin
      rx_valid = 1'b0;
      repeat ($urandom_range(max_gap, 0)) @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = frame_q[i];
      chk("rx_ready_in_session", rx_ready, 1);
      @(negedge clk);
    end
    rx_valid = 1'b0;
  endtask

  task automatic rand_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back($urandom);
  endtask

  task automatic frame1_words();
    words.delete();
    words.push_back(32'h28010005);
    words.push_back(32'hFC000000);
  endtask

  task automatic run_load(input string tag, input bit corrupt, input int gap);
    int base, mm;
    base = we_cnt;
    pulse_start();
    build_frame(words.size(), corrupt);
    send_bytes(frame_q.size(), gap);
    chk({tag, "_done"}, done, corrupt ? 0 : 1);
    chk({tag, "_error"}, error, corrupt ? 1 : 0);
    chk({tag, "_core_hold"}, core_hold, corrupt ? 1 : 0);
    chk({tag, "_word_cnt"}, 32'(word_cnt), words.size());
    chk({tag, "_writes"}, we_cnt - base, words.size());
    chk({tag, "_rx_ready_after"}, rx_ready, 0);
    mm = 0;
    foreach (words[i]) if (tb_mem[i] !== words[i]) mm++;
    chk({tag, "_mem_mismatches"}, mm, 0);
  endtask

  task automatic len_err(input string tag, input int n);
    int base;
    base = we_cnt;
    pulse_start();
    words.delete();
    build_frame(n, 1'b0);
    send_bytes(2, 0);
    chk({tag, "_error_next_cycle"}, error, 1);
    chk({tag, "_core_hold"}, core_hold, 1);
    repeat (4) @(negedge clk);
    chk({tag, "_no_write"}, we_cnt - base, 0);
    chk({tag, "_rx_ready"}, rx_ready, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_core_hold", core_hold, 1);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_word_cnt", word_cnt, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_rx_ready", rx_ready, 0);

    // Frame 1, checksum byte must be 0xD0
    frame1_words();
    build_frame(2, 1'b0);
    chk("frame1_csum", frame_q[10], 8'hD0);
    run_load("frame1", 1'b0, 0);
    chk("frame1_last_addr", last_addr, 1);

    frame1_words();
    run_load("bad_csum", 1'b1, 0);

    len_err("len0", 0);
    len_err("len513", 513);

    rand_words(DEPTH);
    run_load("len512", 1'b0, 0);
    chk("len512_last_addr", last_addr, 511);

    frame1_words();
    run_load("frame1_gaps", 1'b0, 5);
    for (int k = 0; k < 4; k++) begin
      rand_words($urandom_range(8, 1));
      run_load("rand_gaps", 1'b0, 5);
    end

    // Reset after 6 bytes: only the first word lands
    rand_words(4);
    run_load("prefill", 1'b0, 0);
    begin
      int base;
      base = we_cnt;
      frame1_words();
      pulse_start();
      build_frame(2, 1'b0);
      send_bytes(6, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_writes", we_cnt - base, 1);
      chk("rst_mid_mem0", tb_mem[0], 32'h28010005);
      chk("rst_mid_mem1_untouched", tb_mem[1] !== 32'hFC000000, 1);
      chk("rst_mid_rx_ready", rx_ready, 0);
      chk("rst_mid_core_hold", core_hold, 1);
      chk("rst_mid_word_cnt", word_cnt, 0);
    end
    frame1_words();
    run_load("after_rst", 1'b0, 2);

    // start coincident with an accepted DATA byte: byte dropped, session restarts
    frame1_words();
    pulse_start();
    build_frame(2, 1'b0);
    send_bytes(6, 0);
    start = 1'b1; rx_valid = 1'b1; rx_data = 8'hAA;
    @(negedge clk);
    start = 1'b0; rx_valid = 1'b0;
    chk("restart_word_cnt", word_cnt, 0);
    chk("restart_rx_ready", rx_ready, 1);
    chk("restart_done", done, 0);
    chk("restart_core_hold", core_hold, 1);
    rand_words(3);
    build_frame(3, 1'b0);
    begin
      int base, mm;
      base = we_cnt;
      send_bytes(frame_q.size(), 1);
      chk("restart_done_final", done, 1);
      chk("restart_writes", we_cnt - base, 3);
      mm = 0;
      foreach (words[i]) if (tb_mem[i] !== words[i]) mm++;
      chk("restart_mem_mismatches", mm, 0);
    end

    chk("write_count_alignment_violations", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
